// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB bus arbiter that never breaks a fixed burst or a locked
// sequence, tracks the data-phase owner and parks on a default master.
module ahb_master_arbiter #(
    parameter  int NUM_MASTERS = 3,
    parameter  int PARK_MASTER = 0,
    localparam int MST_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [NUM_MASTERS-1:0] lock_i,
    input  logic [1:0]             htrans_i,
    input  logic [2:0]             hburst_i,
    input  logic                   hready_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [MST_W-1:0]       addr_owner_o,
    output logic [MST_W-1:0]       data_owner_o,
    output logic                   locked_o,
    output logic                   burst_active_o
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;

    localparam logic [MST_W-1:0] PARK = MST_W'(PARK_MASTER);

    logic [MST_W-1:0] addr_owner_q, addr_owner_d;
    logic [MST_W-1:0] data_owner_q, data_owner_d;
    logic [MST_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             locked_q, locked_d;

    logic             is_nonseq;
    logic             is_seq;
    logic             owner_lock;
    logic             owner_req;
    logic             arb_point;
    logic             found;
    logic [MST_W-1:0] winner;

    assign is_nonseq  = (htrans_i == HT_NONSEQ);
    assign is_seq     = (htrans_i == HT_SEQ);
    assign owner_lock = lock_i[addr_owner_q];
    assign owner_req  = req_i[addr_owner_q];

    // BUSY never qualifies; INCR bursts end when the owner stops requesting
    always_comb begin
        arb_point = 1'b0;
        if (hready_i && !owner_lock) begin
            arb_point = (htrans_i == HT_IDLE)
                     || (is_nonseq && hburst_i == HB_SINGLE)
                     || (is_seq && cnt_q == 4'd1)
                     || ((is_nonseq || is_seq) && hburst_i == HB_INCR
                         && !owner_req);
        end
    end

    always_comb begin
        int unsigned      idx;
        logic [MST_W-1:0] idx_w;
        found  = 1'b0;
        winner = PARK;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx   = (int'(rr_ptr_q) + i) % NUM_MASTERS;
            idx_w = MST_W'(idx);
            if (!found && req_i[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    always_comb begin
        addr_owner_d = addr_owner_q;
        data_owner_d = data_owner_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        locked_d     = locked_q;
        if (hready_i) begin
            data_owner_d = addr_owner_q;
            locked_d     = owner_lock;
            if (is_nonseq) begin
                unique case (hburst_i[2:1])
                    2'b00:   cnt_d = 4'd0;
                    2'b01:   cnt_d = 4'd3;
                    2'b10:   cnt_d = 4'd7;
                    default: cnt_d = 4'd15;
                endcase
            end else if (is_seq && cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
            if (arb_point) begin
                addr_owner_d = winner;
                if (found) begin
                    rr_ptr_d = winner;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_owner_q <= PARK;
            data_owner_q <= PARK;
            rr_ptr_q     <= PARK;
            cnt_q        <= 4'd0;
            locked_q     <= 1'b0;
        end else begin
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            locked_q     <= locked_d;
        end
    end

    // Grant is decoded from the owner index so it is one-hot by construction
    always_comb begin
        grant_o               = '0;
        grant_o[addr_owner_q] = 1'b1;
    end

    assign addr_owner_o   = addr_owner_q;
    assign data_owner_o   = data_owner_q;
    assign locked_o       = locked_q;
    assign burst_active_o = (cnt_q != 4'd0);

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares the AHB slave fabric between NUM_MASTERS bus masters.
- Selects the master that drives the address phase, which the address decoder and out-of-range filter then see. Also tracks the data-phase owner for the read-data/response mux.
- Round-robin arbitration that never breaks a fixed-length burst or a locked sequence.
- Parks the bus on a default master when no one requests.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- PARK_MASTER, 0, index granted when no requests are pending and after reset.
- MST_W, $clog2(NUM_MASTERS), width of master index outputs (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_MASTERS  per-master bus request (HBUSREQ).
- lock_i  in  NUM_MASTERS  per-master locked-transfer request (HLOCK).
- htrans_i  in  2  HTRANS of the muxed address-phase master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- hburst_i  in  3  HBURST of the muxed address-phase master.
- hready_i  in  1  bus HREADY (transfer accepted / data phase complete).
- grant_o  out  NUM_MASTERS  one-hot grant (HGRANT).
- addr_owner_o  out  MST_W  index of the address-phase owner, drives the address/control mux.
- data_owner_o  out  MST_W  index of the data-phase owner, drives the wdata mux and the rdata/resp steering.
- locked_o  out  1  current owner holds a lock (HMASTLOCK).
- burst_active_o  out  1  a fixed-length burst is in progress.

Behaviour:
- Reset (async, rst_n=0):
  - grant_o = one-hot(PARK_MASTER).
  - addr_owner_o = data_owner_o = PARK_MASTER.
  - locked_o = 0, burst_active_o = 0.
  - Beat counter = 0, round-robin pointer = PARK_MASTER.
- All state updates occur only on rising clk with hready_i=1. With hready_i=0 every register holds; this covers wait states and ERROR first cycles.
- Accepted beat: hready_i=1 and htrans_i is NONSEQ or SEQ.
- Beat counter (4 bits, remaining beats after the current one):
  - Accepted NONSEQ loads it from hburst_i: SINGLE/INCR → 0; WRAP4/INCR4 → 3; WRAP8/INCR8 → 7; WRAP16/INCR16 → 15.
  - Accepted SEQ decrements it, saturating at 0.
  - BUSY and IDLE leave it unchanged.
  - burst_active_o = counter != 0.
- Arbitration point (AP): hready_i=1, owner's lock_i=0, and any one of:
  - htrans_i=IDLE;
  - accepted NONSEQ with hburst_i=SINGLE;
  - accepted SEQ with counter==1 (last beat of a fixed burst);
  - accepted NONSEQ/SEQ with hburst_i=INCR and the owner's req_i=0.
- BUSY is never an AP.
- Arbitration at an AP:
  - Winner is the first requesting index searching from (rr_ptr+1) mod NUM_MASTERS, wrapping.
  - If the owner is the only requester, the owner keeps the grant.
  - If there are no requests, the grant goes to PARK_MASTER.
  - grant_o and addr_owner_o update at that edge, so the new master drives the address phase from the next cycle.
  - rr_ptr is set to the winner (unchanged on park).
- Data-phase owner: on every edge with hready_i=1, data_owner_o <= addr_owner_o. It therefore lags addr_owner_o by exactly one accepted phase.
- Lock: locked_o <= owner's lock_i on every hready edge. A locked owner keeps the grant through any htrans until lock_i drops and a subsequent AP occurs.
- Outside an AP, grant_o is held regardless of req_i changes.
- Simultaneous events:
  - Owner drops req_i and another master raises it in the same AP cycle → the other master wins.
  - Requests arriving with hready_i=0 are evaluated at the next hready edge that is an AP.
- Reset mid-burst: outputs return to reset values immediately (async). The beat count is discarded.
- grant_o is always exactly one-hot. Bench asserts $onehot(grant_o) every cycle.

Test Plan:
- Reset, no requests → grant_o=3'b001, addr/data owner=0, locked_o=0, burst_active_o=0; hold 10 cycles unchanged.
- req_i=3'b110, single NONSEQ/SINGLE transfers, hready_i=1 → grant rotates 1→2→1→2 every cycle. data_owner_o follows addr_owner_o one cycle later.
- Master 1 issues INCR4 (NONSEQ+3 SEQ), master 2 requests from beat 1 → grant stays 1 until the 4th beat is accepted, then moves to 2 on the next edge. burst_active_o high for beats 1..3.
- Same INCR4 with hready_i=0 for 2 cycles at beat 2 → counter, grant and data_owner frozen; handover delayed exactly 2 cycles.
- Master 0 lock_i=1 during SINGLE transfers while req_i=3'b111 → grant stays 0 and locked_o=1. Grant moves to 1 at the first AP after lock_i drops.
- rst_n pulsed low mid-WRAP8 at beat 3 → grant_o=3'b001 and burst_active_o=0 within the same cycle; normal arbitration after release.
